// File: rtl/sdram_arb_pkg.sv
// Shared types and RAM-port widths for the sdram_axi_core request-port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  localparam int WR_W   = 4;
  localparam int LEN_W  = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

endpackage

// File: rtl/sdram_arb_rr_pick.sv
// Round-robin picker: first active requester at or after the rr pointer, wrapping.
module sdram_arb_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     active_i,
  input  logic [IDX_W-1:0] rr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [N-1:0]     rot_s;
  logic [IDX_W-1:0] pos_s;

  function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
    return (v >= N) ? IDX_W'(v - N) : IDX_W'(v);
  endfunction

  // Rotate so rr sits at bit 0, take the lowest set bit, rotate the index back.
  always_comb begin
    rot_s = '0;
    pos_s = '0;
    for (int i = 0; i < N; i++) begin
      rot_s[i] = active_i[wrap_idx(i + int'(rr_i))];
    end
    for (int i = N - 1; i >= 0; i--) begin
      pos_s = rot_s[i] ? IDX_W'(i) : pos_s;
    end
    found_o = |rot_s;
    idx_o   = wrap_idx(int'(pos_s) + int'(rr_i));
  end

endmodule

// File: rtl/sdram_axi_arbiter.sv
// Shares one sdram_axi_core RAM request port between NUM_REQ requesters.
// Grant is held until every ack of the granted transaction is back, so responses need no ID.
module sdram_axi_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int OUT_W   = 9
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ*WR_W-1:0]   req_wr_i,
  input  logic [NUM_REQ-1:0]        req_rd_i,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_write_data_i,
  output logic [NUM_REQ-1:0]        req_accept_o,
  output logic [NUM_REQ-1:0]        req_ack_o,
  output logic [NUM_REQ-1:0]        req_error_o,
  output logic [DATA_W-1:0]         req_read_data_o,
  output logic [WR_W-1:0]           ram_wr_o,
  output logic                      ram_rd_o,
  output logic [LEN_W-1:0]          ram_len_o,
  output logic [ADDR_W-1:0]         ram_addr_o,
  output logic [DATA_W-1:0]         ram_write_data_o,
  input  logic                      ram_accept_i,
  input  logic                      ram_ack_i,
  input  logic                      ram_error_i,
  input  logic [DATA_W-1:0]         ram_read_data_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   g_q, g_d, rr_q, rr_d, pick_idx_s;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [OUT_W-1:0]   outstanding_q, outstanding_d, add_s;
  logic [NUM_REQ-1:0] active_s;
  logic               pick_found_s, accept_ev_s, ack_valid_s;
  logic [WR_W-1:0]    g_wr_s;
  logic               g_rd_s;
  logic [LEN_W-1:0]   g_len_s;
  logic [ADDR_W-1:0]  g_addr_s;
  logic [DATA_W-1:0]  g_wdata_s;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      active_s[i] = req_rd_i[i] | (|req_wr_i[i*WR_W +: WR_W]);
    end
  end

  sdram_arb_rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .active_i (active_s),
    .rr_i     (rr_q),
    .found_o  (pick_found_s),
    .idx_o    (pick_idx_s)
  );

  assign g_wr_s    = req_wr_i[g_q*WR_W +: WR_W];
  assign g_rd_s    = req_rd_i[g_q];
  assign g_len_s   = req_len_i[g_q*LEN_W +: LEN_W];
  assign g_addr_s  = req_addr_i[g_q*ADDR_W +: ADDR_W];
  assign g_wdata_s = req_write_data_i[g_q*DATA_W +: DATA_W];

  // Acks with nothing outstanding are dropped, which also keeps the counter from underflowing.
  assign ack_valid_s   = ram_ack_i & (outstanding_q != '0);
  assign accept_ev_s   = (state_q == ST_GRANT) & ram_accept_i & active_s[g_q];
  assign add_s         = !accept_ev_s ? '0 :
                         g_rd_s ? (OUT_W'(g_len_s) + OUT_W'(1)) : OUT_W'(1);
  assign outstanding_d = outstanding_q + add_s - OUT_W'(ack_valid_s);

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    rr_d       = rr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          g_d        = pick_idx_s;
          beat_cnt_d = '0;
          state_d    = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (accept_ev_s) begin
          if (g_rd_s || (beat_cnt_q == g_len_s)) begin
            state_d = ST_DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
          end
        end else if (!active_s[g_q] && (beat_cnt_q == '0)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GRANT;
        end
      end
      ST_DRAIN: begin
        if (outstanding_d == '0) begin
          rr_d    = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + IDX_W'(1);
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_wr_o         = '0;
    ram_rd_o         = 1'b0;
    ram_len_o        = '0;
    ram_addr_o       = '0;
    ram_write_data_o = '0;
    req_accept_o     = '0;
    req_ack_o        = '0;
    req_error_o      = '0;
    req_read_data_o  = '0;
    if (state_q == ST_GRANT) begin
      ram_wr_o           = g_wr_s;
      ram_rd_o           = g_rd_s;
      ram_len_o          = g_len_s;
      ram_addr_o         = g_addr_s;
      ram_write_data_o   = g_wdata_s;
      req_accept_o[g_q]  = ram_accept_i;
    end else begin
      req_accept_o = '0;
    end
    if (ack_valid_s) begin
      req_ack_o[g_q]   = 1'b1;
      req_error_o[g_q] = ram_error_i;
      req_read_data_o  = ram_read_data_i;
    end else begin
      req_read_data_o = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      g_q           <= '0;
      rr_q          <= '0;
      beat_cnt_q    <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      g_q           <= g_d;
      rr_q          <= rr_d;
      beat_cnt_q    <= beat_cnt_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule
